// File: rtl/wb_blinky_regs.sv
// wb_blinky_regs
// Wishbone classic register responder for a programmable LED blinker.
// Firmware on the MCU sets the blink period and pattern mode and receives an
// interrupt each time the tick counter wraps.
//
// Ports:
//   clock      rising-edge system clock
//   reset_n    asynchronous active-low reset
//   wb_adr_i   byte address; only [4:2] decoded, upper bits alias
//   wb_dat_i   write data
//   wb_sel_i   write byte-lane enables
//   wb_we_i    write enable
//   wb_cyc_i   bus cycle active
//   wb_stb_i   strobe
//   wb_dat_o   read data, non-zero only in the ack cycle
//   wb_ack_o   single-cycle acknowledge, one cycle after the request
//   led_o      registered LED drive, active-high
//   irq_o      level interrupt: WRAP & IRQ_EN
//
// Register map (adr[4:2]):
//   0 ID      RO  ID_VALUE
//   1 CTRL    RW  [0] RUN [1] IRQ_EN [2] MANUAL [5:3] LED_MAN
//   2 PERIOD  RW  [CNT_W-1:0]
//   3 COUNT   RO  zero-extended tick counter
//   4 STATUS  [0] WRAP, write-1-to-clear
//   5..7      read 0, writes ignored
module wb_blinky_regs #(
  parameter logic [31:0]      ID_VALUE       = 32'h424C_4E4B,
  parameter int               CNT_W          = 24,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(11_999_999)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [16:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [2:0]  led_o,
  output logic        irq_o
);

  localparam logic [2:0] A_ID     = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  // Control / status state
  logic             run;
  logic             irq_en;
  logic             manual;
  logic [2:0]       led_man;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] count;
  logic [2:0]       pattern;
  logic             wrap;

  // Bus decode. Masking with ~ack keeps a held strobe from being taken twice,
  // so back-to-back requests are served at most every other cycle.
  logic       req;
  logic       wr;
  logic [2:0] reg_sel;

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign reg_sel = wb_adr_i[4:2];

  logic wr_ctrl, wr_period, wr_status;
  assign wr_ctrl   = wr & (reg_sel == A_CTRL) & wb_sel_i[0];
  assign wr_period = wr & (reg_sel == A_PERIOD);
  assign wr_status = wr & (reg_sel == A_STATUS) & wb_sel_i[0] & wb_dat_i[0];

  // Byte-lane merge for PERIOD; unselected lanes keep their current value.
  logic [31:0]      lane_mask;
  logic [CNT_W-1:0] period_wr;

  assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                      {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign period_wr = (period & ~lane_mask[CNT_W-1:0])
                   | (wb_dat_i[CNT_W-1:0] & lane_mask[CNT_W-1:0]);

  // Read mux; sampled into wb_dat_o on the edge that raises ack, so a read
  // returns the value held before that edge.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      A_ID:     rdata = ID_VALUE;
      A_CTRL:   rdata = {26'd0, led_man, manual, irq_en, run};
      A_PERIOD: rdata = 32'(period);
      A_COUNT:  rdata = 32'(count);
      A_STATUS: rdata = {31'd0, wrap};
      default:  rdata = '0;
    endcase
  end

  // Wrap when the counter reaches or has overshot PERIOD. Using >= means a
  // PERIOD shrunk below COUNT wraps immediately instead of rolling over.
  logic wrap_evt;
  assign wrap_evt = run & (count >= period);

  // Bus response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
    end
  end

  // Register writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run     <= 1'b0;
      irq_en  <= 1'b0;
      manual  <= 1'b0;
      led_man <= '0;
      period  <= DEFAULT_PERIOD;
    end else begin
      if (wr_ctrl) begin
        run     <= wb_dat_i[0];
        irq_en  <= wb_dat_i[1];
        manual  <= wb_dat_i[2];
        led_man <= wb_dat_i[5:3];
      end
      if (wr_period) period <= period_wr;
    end
  end

  // Tick engine and LED drive. The tick uses the CTRL/PERIOD values in place
  // before any write committed on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      pattern <= '0;
      wrap    <= 1'b0;
      led_o   <= '0;
    end else begin
      if (run) count <= wrap_evt ? '0 : count + CNT_W'(1);
      if (wrap_evt) pattern <= pattern + 3'd1;
      // A new wrap outranks a simultaneous write-1-to-clear.
      if (wrap_evt)       wrap <= 1'b1;
      else if (wr_status) wrap <= 1'b0;
      led_o <= manual ? led_man : pattern;
    end
  end

  assign irq_o = wrap & irq_en;

endmodule

// File: tb/tb_wb_blinky_regs.sv
// Testbench for wb_blinky_regs: directed steps plus a randomized phase, all
// checked against an arithmetic model of the tick counter (closed-form wrap
// counting over spans of cycles rather than a per-cycle replica).
module tb_wb_blinky_regs;
  localparam logic [31:0] ID   = 32'h424C_4E4B;
  localparam longint      DEFP = 11_999_999;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [16:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [2:0]  led_o;
  logic        irq_o;

  wb_blinky_regs dut (
    .clock(clock), .reset_n(reset_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .led_o(led_o), .irq_o(irq_o)
  );

  always #5 clock = ~clock;

  // Edge counter: value after edge E is E.
  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_count, m_period;
  int     m_pat, m_ledman, m_edge;
  bit     m_wrap, m_run, m_irqen, m_manual, last_wrap;

  function automatic void model_reset();
    m_count = 0; m_period = DEFP; m_pat = 0; m_wrap = 0;
    m_run = 0; m_irqen = 0; m_manual = 0; m_ledman = 0; m_edge = cyc_cnt;
  endfunction

  // Bring the model forward to the state after edge e. Counts how many
  // wraps happen in k running cycles with modular arithmetic.
  function automatic void advance(input int e);
    longint k, w;
    k = longint'(e - m_edge);
    last_wrap = 0;
    if (m_run && k > 0) begin
      if (m_count > m_period) begin
        w = 1 + (k - 1) / (m_period + 1);
        m_count = (k - 1) % (m_period + 1);
      end else begin
        w = (m_count + k) / (m_period + 1);
        m_count = (m_count + k) % (m_period + 1);
      end
      m_pat = int'((longint'(m_pat) + w) % 8);
      if (w > 0) m_wrap = 1;
      last_wrap = (m_count == 0);  // an increment never yields 0
    end
    if (e > m_edge) m_edge = e;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return ID;
      1: return {26'd0, 3'(m_ledman), m_manual, m_irqen, m_run};
      2: return 32'(m_period);
      3: return 32'(m_count);
      4: return {31'd0, m_wrap};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [16:0] mk_adr(input int idx);
    return {12'($urandom), 3'(idx), 2'($urandom)};
  endfunction

  // ---------------- bus access ----------------
  task automatic bus(input bit we, input int idx, input logic [31:0] dat, input logic [3:0] sel,
                     output logic [31:0] rd, output int e);
    int start;
    @(negedge clock);
    start = cyc_cnt;
    wb_adr_i = mk_adr(idx); wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    e = -1; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (wb_ack_o) begin e = cyc_cnt; rd = wb_dat_o; break; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("ack_latency", e, start + 1);
    @(posedge clock); #1;
    check("ack_width", {31'd0, wb_ack_o}, 32'd0);
    check("dat_idle", wb_dat_o, 32'd0);
  endtask

  task automatic wr(input int idx, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    int e;
    bus(1'b1, idx, dat, sel, rd, e);
    if (e < 0) return;
    advance(e);
    case (idx)
      1: if (sel[0]) begin
           m_run = dat[0]; m_irqen = dat[1]; m_manual = dat[2]; m_ledman = int'(dat[5:3]);
         end
      2: for (int b = 0; b < 3; b++)
           if (sel[b])
             m_period = (m_period & ~(longint'(255) << (8 * b)))
                      | (longint'((dat >> (8 * b)) & 32'hFF) << (8 * b));
      4: if (sel[0] && dat[0]) m_wrap = last_wrap;
      default: ;
    endcase
  endtask

  task automatic rd_chk(input string tag, input int idx, output logic [31:0] rd);
    int e;
    bus(1'b0, idx, 32'h0, 4'h0, rd, e);
    if (e < 0) return;
    advance(e - 1);
    check(tag, rd, model_read(idx));
  endtask

  // Check LED and IRQ against the model at the current edge.
  task automatic chk_live();
    logic [2:0] exp_led;
    advance(cyc_cnt - 1);
    exp_led = m_manual ? 3'(m_ledman) : 3'(m_pat);
    advance(cyc_cnt);
    check("led", {29'd0, led_o}, {29'd0, exp_led});
    check("irq", {31'd0, irq_o}, {31'd0, m_wrap & m_irqen});
  endtask

  logic [31:0] r;
  int es;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_led", {29'd0, led_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();

    // ID, PERIOD default
    rd_chk("id", 0, r);
    check("id_const", r, ID);
    rd_chk("period_rst", 2, r);

    // PERIOD=3, RUN: wrap every 4 cycles, LEDs step
    wr(2, 32'd3, 4'hF);
    wr(1, 32'd1, 4'hF);
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      chk_live();
    end
    for (int i = 0; i < 3; i++) rd_chk("count_run", 3, r);
    rd_chk("status_wrap", 4, r);

    // IRQ rise/fall
    wr(1, 32'd0, 4'hF);
    wr(4, 32'd1, 4'hF);
    check("irq_low", {31'd0, irq_o}, 32'd0);
    wr(1, 32'd3, 4'hF);
    for (int i = 0; i < 10 && !irq_o; i++) begin
      @(posedge clock); #1;
      chk_live();
    end
    check("irq_rise", {31'd0, irq_o}, 32'd1);
    wr(1, 32'd2, 4'hF);
    wr(4, 32'd1, 4'hF);
    chk_live();
    check("irq_fall", {31'd0, irq_o}, 32'd0);

    // Clear on the same edge as a wrap: set wins
    wr(2, 32'd0, 4'hF);
    wr(1, 32'd3, 4'hF);
    wr(4, 32'd1, 4'hF);
    rd_chk("wrap_set_wins", 4, r);
    check("wrap_set_wins_c", r, 32'd1);
    chk_live();

    // Shrink PERIOD below COUNT
    wr(1, 32'd0, 4'hF);
    wr(2, 32'd100, 4'hF);
    wr(4, 32'd1, 4'hF);
    wr(1, 32'd1, 4'hF);
    es = m_edge;
    while (cyc_cnt < es + 10) @(posedge clock);
    #1;
    wr(2, 32'd5, 4'hF);
    wr(1, 32'd0, 4'hF);
    rd_chk("count_shrink", 3, r);
    rd_chk("wrap_shrink", 4, r);
    check("wrap_shrink_c", r, 32'd1);

    // Byte lanes on CTRL, manual LEDs, sel=0
    wr(1, 32'hFFFF_FFFF, 4'b0001);
    rd_chk("ctrl_sel", 1, r);
    check("ctrl_sel_c", r, 32'h0000_003F);
    wr(1, 32'h0000_0034, 4'hF);
    check("led_manual", {29'd0, led_o}, 32'd6);
    wr(1, 32'h0000_0001, 4'h0);
    rd_chk("ctrl_sel0", 1, r);
    wr(2, 32'h0012_3456, 4'b0010);
    rd_chk("period_lane", 2, r);

    // Unmapped addresses
    wr(6, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped", 6, r);
    check("unmapped_c", r, 32'd0);

    // Randomized phase
    wr(2, 32'd7, 4'hF);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: wr(2, $urandom_range(0, 15), 4'($urandom));
        1: wr(1, $urandom, 4'($urandom));
        2: wr(4, $urandom, 4'($urandom));
        3: wr($urandom_range(5, 7), $urandom, 4'hF);
        default: rd_chk("rand_rd", $urandom_range(0, 7), r);
      endcase
      repeat ($urandom_range(0, 5)) @(posedge clock);
      #1;
      chk_live();
    end
    for (int i = 0; i < 5; i++) rd_chk("rand_final", i, r);

    // Reset during an ack cycle
    wr(2, 32'd9, 4'hF);
    @(negedge clock);
    wb_adr_i = mk_adr(0); wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clock); #1;
    check("ack_before_rst", {31'd0, wb_ack_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("ack_killed", {31'd0, wb_ack_o}, 32'd0);
    check("dat_killed", wb_dat_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    rd_chk("period_after_rst", 2, r);
    check("period_after_rst_c", r, 32'(DEFP));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
